// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit that owns the HI/LO registers.
// One request is accepted at a time through a start/busy/done handshake.
// A request takes N RUN steps followed by one FIX cycle.
// Optional feature macro: MULDIV_SIGNED_EN.
//   Defined:   ops 00/10 are signed multiply/divide.
//   Undefined: every op is treated as unsigned. The sign logic is tied off and folds away.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_div_by_zero,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo
);

`ifdef MULDIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_done;
  logic           r_dbz;
  logic           r_isDiv;
  logic           r_yZero;
  logic           r_negMain;
  logic           r_negRem;
  logic [N-1:0]   r_opnd;
  logic [N-1:0]   r_x;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_hi;
  logic [N-1:0]   r_lo;

  logic           w_signedReq;
  logic           w_xNeg;
  logic           w_yNeg;
  logic [N-1:0]   w_absX;
  logic [N-1:0]   w_absY;
  logic [N:0]     w_mulSum;
  logic [2*N-1:0] w_mulNext;
  logic [N:0]     w_remSh;
  logic [N+1:0]   w_diff;
  logic [2*N-1:0] w_divNext;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_quot;
  logic [N-1:0]   w_rem;
  logic [N-1:0]   w_fixHi;
  logic [N-1:0]   w_fixLo;

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

  // Operand magnitudes and sign flags captured at the accept edge.
  always_comb begin
    w_signedReq = SignedEn & ~i_op[0];
    w_xNeg      = w_signedReq & i_x[N-1];
    w_yNeg      = w_signedReq & i_y[N-1];
    w_absX      = w_xNeg ? -i_x : i_x;
    w_absY      = w_yNeg ? -i_y : i_y;
  end

  // One shift-add step and one restoring-division step, both computed every cycle.
  always_comb begin
    w_mulSum  = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_opnd};
    w_mulNext = r_acc[0] ? {w_mulSum, r_acc[N-1:1]} : {1'b0, r_acc[2*N-1:1]};
    w_remSh   = r_acc[2*N-1:N-1];
    w_diff    = {1'b0, w_remSh} - {2'b00, r_opnd};
    w_divNext = w_diff[N+1] ? {r_acc[2*N-2:0], 1'b0}
                            : {w_diff[N-1:0], r_acc[N-2:0], 1'b1};
  end

  // Sign correction and divide-by-zero forcing for the FIX write.
  always_comb begin
    w_prod  = r_negMain ? -r_acc : r_acc;
    w_quot  = r_negMain ? -r_acc[N-1:0] : r_acc[N-1:0];
    w_rem   = r_negRem ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];
    w_fixHi = w_prod[2*N-1:N];
    w_fixLo = w_prod[N-1:0];
    if (r_isDiv) begin
      if (r_yZero) begin
        w_fixHi = r_x;
        w_fixLo = '1;
      end else begin
        w_fixHi = w_rem;
        w_fixLo = w_quot;
      end
    end
  end

  // Control FSM: IDLE accepts, RUN counts N steps, FIX raises done for one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_dbz   <= r_isDiv & r_yZero;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Operand latch at accept, then the iterative accumulator during RUN.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_isDiv   <= 1'b0;
      r_yZero   <= 1'b0;
      r_negMain <= 1'b0;
      r_negRem  <= 1'b0;
      r_opnd    <= '0;
      r_x       <= '0;
      r_acc     <= '0;
    end else if (r_state == S_IDLE) begin
      if (i_start) begin
        r_isDiv   <= i_op[1];
        r_yZero   <= (i_y == '0);
        r_negMain <= w_xNeg ^ w_yNeg;
        r_negRem  <= i_op[1] & w_xNeg;
        r_x       <= i_x;
        if (i_op[1]) begin
          r_opnd <= w_absY;
          r_acc  <= {{N{1'b0}}, w_absX};
        end else begin
          r_opnd <= w_absX;
          r_acc  <= {{N{1'b0}}, w_absY};
        end
      end
    end else if (r_state == S_RUN) begin
      r_acc <= r_isDiv ? w_divNext : w_mulNext;
    end
  end

  // HI/LO change only on the FIX edge and are cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_fixHi;
      r_lo <= w_fixLo;
    end
  end

endmodule
